// File: rtl/cd_7seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Drives one shared BCD decoder and one active-low anode at a time,
// with a double-buffered digit image swapped only at frame boundaries.
module cd_7seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned IDX_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    lzb,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int unsigned IMG_W      = 4 * NUM_DIGITS;
  localparam int unsigned MAX_CYC    = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYC + 1);
  localparam int unsigned BLANK_LAST = BLANK_CYCLES - 1;
  localparam int unsigned DIGIT_LAST = DIGIT_CYCLES - 1;
  localparam int unsigned LAST_IDX   = NUM_DIGITS - 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IMG_W-1:0]        shadow_q, shadow_d;
  logic [IMG_W-1:0]        active_q, active_d;
  logic                    pending_q, pending_d;
  logic                    tick_q, tick_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    boundary_c;
  logic                    zero_run_c;
  logic [NUM_DIGITS-1:0]   sup_c;

  // State, counters, image buffers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      an_n_q    <= '1;
      bcd_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      an_n_q    <= an_n_d;
      bcd_q     <= bcd_d;
    end
  end

  // Next-state sequencing, buffer swap and output decode from next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    boundary_c = 1'b0;
    tick_d     = 1'b0;
    an_n_d     = '1;
    bcd_d      = 4'd0;
    zero_run_c = lzb;
    sup_c      = '0;

    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        idx_d = '0;
        if (en) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_LAST)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_W'(DIGIT_LAST)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_W'(LAST_IDX)) begin
            idx_d      = '0;
            boundary_c = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Scan disable wins over everything and suppresses the frame boundary
    if (!en) begin
      state_d    = ST_OFF;
      cnt_d      = '0;
      idx_d      = '0;
      boundary_c = 1'b0;
    end

    tick_d = boundary_c;

    // Image update: direct in OFF or at a boundary, otherwise via shadow
    if ((state_q == ST_OFF) && load) begin
      shadow_d  = digits;
      active_d  = digits;
      pending_d = 1'b0;
    end else if (boundary_c) begin
      if (load) begin
        shadow_d = digits;
        active_d = digits;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = digits;
      pending_d = 1'b1;
    end

    // Leading-zero suppression, scanning down from the most significant digit
    for (int i = int'(LAST_IDX); i >= 1; i--) begin
      zero_run_c = zero_run_c && (active_d[4*i +: 4] == 4'd0);
      sup_c[i]   = zero_run_c;
    end

    // Outputs track the next state so registered outputs match state_q
    if (state_d != ST_OFF) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (idx_d == IDX_W'(i)) begin
          bcd_d = active_d[4*i +: 4];
          if ((state_d == ST_DRIVE) && !sup_c[i]) an_n_d[i] = 1'b0;
        end
      end
    end
  end

  assign bcd        = bcd_q;
  assign an_n       = an_n_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_cd_7seg_scan_ctrl.sv
// Scoreboard bench for cd_7seg_scan_ctrl: expected per-cycle outputs are
// queued up front, a negedge monitor pops and compares them by cycle number.
module tb_cd_7seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int NEVER = 1000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] digits;
  logic        lzb;
  logic [3:0]  bcd;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_tick;
  logic        pending;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] bcd;
    logic       bcd_chk;
    logic [1:0] idx;
    logic       tick;
    logic       pend;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cd_7seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(4),
    .BLANK_CYCLES(2),
    .IDX_W       (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .digits    (digits),
    .lzb       (lzb),
    .bcd       (bcd),
    .an_n      (an_n),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_one(input int c, input logic [3:0] an, input logic [3:0] b,
                          input logic bchk, input logic [1:0] idx,
                          input logic tk, input logic pd);
    exp_t e;
    e.cyc = c; e.an = an; e.bcd = b; e.bcd_chk = bchk;
    e.idx = idx; e.tick = tk; e.pend = pd;
    q.push_back(e);
  endtask

  // One frame: per digit 2 blank cycles then 4 drive cycles
  task automatic push_frame(input int base, input logic [15:0] img, input logic [3:0] lit,
                            input bit tick_first, input int pend_rise, input int lim);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 6; j++) begin
        int         c;
        logic [3:0] an;
        c  = base + 6*k + j;
        an = (j >= 2 && lit[k]) ? ~(4'b0001 << k) : 4'hF;
        if (c < lim)
          push_one(c, an, img[4*k +: 4], 1'b1, 2'(k),
                   (tick_first && k == 0 && j == 0) ? 1'b1 : 1'b0,
                   (c >= pend_rise) ? 1'b1 : 1'b0);
      end
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: per-cycle anode sanity plus scoreboard compare
  always @(negedge clk) begin
    n_cmp++;
    if ($countones(~an_n) > 1) begin
      n_bad++;
      $display("FAIL onehot cyc=%0d an_n=%b (at most one low bit allowed)", cyc, an_n);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      n_cmp++;
      if (mon_e.cyc < cyc) begin
        n_bad++;
        $display("FAIL missed entry cyc=%0d (now %0d)", mon_e.cyc, cyc);
      end else if (an_n !== mon_e.an || digit_idx !== mon_e.idx ||
                   frame_tick !== mon_e.tick || pending !== mon_e.pend ||
                   (mon_e.bcd_chk && bcd !== mon_e.bcd)) begin
        n_bad++;
        $display("FAIL scan cyc=%0d got an_n=%b bcd=%h idx=%0d tick=%b pend=%b exp an_n=%b bcd=%h idx=%0d tick=%b pend=%b",
                 cyc, an_n, bcd, digit_idx, frame_tick, pending,
                 mon_e.an, mon_e.bcd, mon_e.idx, mon_e.tick, mon_e.pend);
      end
    end
  end

  // Watchdog bound on the whole run
  initial begin
    #20000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; load = 1'b0; digits = 16'h0000; lzb = 1'b0;
    #2 rst_n = 1'b0;

    // Reset values, then OFF after a load (bcd not defined in OFF)
    push_one(2, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0);
    push_one(5, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    // F1: 1234 loaded while OFF
    push_frame(6,   16'h1234, 4'b1111, 1'b0, NEVER, NEVER);
    // F2: 5678 loaded during digit 1 drive -> pending from cycle 39
    push_frame(30,  16'h1234, 4'b1111, 1'b1, 39,    NEVER);
    // F3: shadow applied at boundary
    push_frame(54,  16'h5678, 4'b1111, 1'b1, NEVER, NEVER);
    // F4: 9999 loaded exactly on the boundary, pending never rises
    push_frame(78,  16'h9999, 4'b1111, 1'b1, NEVER, NEVER);
    // F5: lzb with 0070 -> digits 3 and 2 dark
    push_frame(102, 16'h0070, 4'b0011, 1'b1, NEVER, NEVER);
    // F6: lzb with 0000 -> only digit 0 lit
    push_frame(126, 16'h0000, 4'b0001, 1'b1, NEVER, NEVER);
    // F7: 4321, shadow load 8888 mid-frame, en dropped during digit 2 drive
    push_frame(150, 16'h4321, 4'b1111, 1'b1, 159,   166);
    for (int c = 166; c < 170; c++) push_one(c, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    // F8: restart from digit 0, no tick, pending retained
    push_frame(170, 16'h4321, 4'b1111, 1'b0, 0,     NEVER);
    // F9: pending applied, then async reset during digit 1 drive
    push_frame(194, 16'h8888, 4'b1111, 1'b1, 197,   203);
    push_one(203, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0);
    push_one(204, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0);

    at_cyc(3);   rst_n = 1'b1;
    at_cyc(4);   load = 1'b1; digits = 16'h1234;
    at_cyc(5);   load = 1'b0; en = 1'b1;
    at_cyc(38);  load = 1'b1; digits = 16'h5678;
    at_cyc(39);  load = 1'b0;
    at_cyc(77);  load = 1'b1; digits = 16'h9999;
    at_cyc(78);  load = 1'b0;
    at_cyc(101); load = 1'b1; digits = 16'h0070; lzb = 1'b1;
    at_cyc(102); load = 1'b0;
    at_cyc(125); load = 1'b1; digits = 16'h0000;
    at_cyc(126); load = 1'b0;
    at_cyc(149); load = 1'b1; digits = 16'h4321; lzb = 1'b0;
    at_cyc(150); load = 1'b0;
    at_cyc(158); load = 1'b1; digits = 16'h8888;
    at_cyc(159); load = 1'b0;
    at_cyc(165); en = 1'b0;
    at_cyc(169); en = 1'b1;
    at_cyc(196); load = 1'b1; digits = 16'h1111;
    at_cyc(197); load = 1'b0;
    at_cyc(203); #2 rst_n = 1'b0;
    at_cyc(205); rst_n = 1'b1;
    at_cyc(209);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover entries=%0d expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
